dcache_access_stage: RTL and testbench
======================================

// Module: dcache_access_stage
// PURPOSE
// - Memory-access stage directly downstream of the cache pipeline register; consumes its registered
//   address (tlb_result), store data, ldSt_enable and forwarded control fields.
// - Direct-mapped, write-through, no-write-allocate data cache with line-fill FSM to external memory.
// - Produces load data plus forwarded fields into the writeback pipeline register.
// - Raises stall to freeze upstream (drives enable_cache low) during misses and stores.
// PARAMETERS
// - NUM_LINES   16  cache lines (power of 2)
// - LINE_WORDS  4   16-bit words per line (power of 2)
// - ADDR_W      16  byte-address width
// - DATA_W      16  data word width
// PORTS
// - clk           in   1   clock, rising edge
// - reset         in   1   asynchronous, active-low reset
// - addr_in       in   16  effective address (tlb_result); bit0 ignored, word aligned
// - st_data_in    in   16  store data (dataReg)
// - ldst_in       in   2   01=load, 10=store, 00/11=no memory op
// - destReg_in    in   3   fwd: destination register
// - we_in         in   1   fwd: register-file write enable
// - bp_in         in   2   fwd: bypass selector
// - tail_rob_in   in   3   fwd: ROB tail tag
// - pc_in         in   16  fwd: instruction PC
// - ex_vector_in  in   2   fwd: exception vector; nonzero => memory op suppressed
// - ticketWE_in   in   1   fwd: ROB ticket write enable
// - stall         out  1   combinational; 1 => upstream must hold all *_in stable
// - mem_req       out  1   memory request valid
// - mem_we        out  1   1=write, 0=read
// - mem_addr      out  16  memory byte address
// - mem_wdata     out  16  memory write data
// - mem_ack       in   1   request accepted/completed this cycle
// - mem_rdata     in   16  read data, valid when mem_ack && !mem_we
// - wb_result     out  16  load data, else addr_in passthrough (ALU result)
// - wb_destReg, wb_we, wb_bp, wb_tail_rob, wb_pc, wb_ex_vector, wb_ticketWE: registered fwd fields
// BEHAVIOUR
// - Reset (async, reset==0): all valid bits 0, FSM IDLE, mem_req 0, all wb_* outputs 0; an in-flight
//   fill/write is abandoned, mem_req drops immediately.
// - Address split: offset=[log2(LINE_WORDS):1], index=next log2(NUM_LINES) bits, tag=remaining upper.
// - FSM: IDLE, FILL, WRITE, REPLAY.
// - IDLE, no op or ex_vector_in!=0: stall=0; wb_* capture inputs next edge; wb_result=addr_in.
// - IDLE load hit: stall=0; wb_result=array word at next edge (latency 1).
// - IDLE load miss: stall=1 same cycle; ->FILL, word counter=0.
// - FILL: mem_req=1, mem_we=0, mem_addr={tag,index,cnt,1'b0}; on mem_ack write mem_rdata to
//   array[index][cnt], cnt++; after ack of word LINE_WORDS-1 set tag/valid, ->REPLAY.
// - REPLAY: stall=0, load now hits; wb_* capture, ->IDLE. Fill latency = LINE_WORDS acks + 2 cycles.
// - IDLE store: stall=1; ->WRITE. On hit, array word updated at entry edge; miss leaves array unchanged.
// - WRITE: mem_req=1, mem_we=1, mem_addr=addr_in, mem_wdata=st_data_in; on mem_ack stall=0 that
//   cycle, wb_* capture, ->IDLE.
// - mem_req, mem_we, mem_addr, mem_wdata held stable from assertion until the mem_ack cycle;
//   mem_ack may arrive in the first request cycle; mem_ack outside a request is ignored.
// - While stall=1: wb_* load a bubble (wb_we=0, wb_ticketWE=0, wb_ex_vector=0, others 0).
// - ldst_in==11 treated as no op; no exception is raised by this stage.
// STRUCTURE
// - cache_pkg: FSM state encoding, LDST_LOAD/LDST_STORE codes, derived OFFSET_W/INDEX_W/TAG_W.
// - Sub-module dcache_array: valid/tag/data storage, 1 read port, 1 word-write port, tag-write,
//   async-clear of valid bits on reset.
// - Top: FSM, word counter, hit compare, memory interface, wb pipeline register.
// TESTING
// - Reset mid-FILL (after 2 acks) -> mem_req 0 at once; reload same addr -> misses again.
// - Load 0x0104 cold -> stall, reads 0x0100..0x0106 (mem=0xA0..0xA3) -> wb_result=0xA2 at REPLAY+1.
// - Load 0x0106 after fill -> stall=0, wb_result=0xA3 one cycle later, no mem_req.
// - Store 0x5555 to 0x0102 (hit), ack after 3 cycles -> 3 stall cycles + bubbles; load 0x0102 -> 0x5555.
// - Store to 0x0902 (miss) -> one mem write; load 0x0102 still hits; load 0x0902 -> fill.
// - Load 0x0202 with ex_vector_in=01 -> no mem_req, stall=0, wb_ex_vector=01, wb_result=0x0202.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, op codes and FSM encoding for the data-cache access stage
package cache_pkg;
  localparam int NUM_LINES  = 16;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int OFFSET_W   = $clog2(LINE_WORDS);
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = ADDR_W - 1 - OFFSET_W - INDEX_W;
  localparam logic [1:0] LDST_LOAD  = 2'b01;
  localparam logic [1:0] LDST_STORE = 2'b10;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, REPLAY} state_e;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage with one read port, one word-write port and a tag write
module dcache_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [DATA_W-1:0]   rd_data_o,
  input  logic                wr_en_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                tag_we_i,
  input  logic [TAG_W-1:0]    tag_i
);
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES*LINE_WORDS];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[{idx_i, rd_off_i}];
  // valid bits clear asynchronously; a tag write marks the line valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) valid_q <= '0;
    else if (tag_we_i) valid_q[idx_i] <= 1'b1;
  // tag and data storage carry no reset; validity alone gates their use
  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[idx_i] <= tag_i;
    if (wr_en_i) data_q[{idx_i, wr_off_i}] <= wr_data_i;
  end
endmodule

// File: rtl/dcache_access_stage.sv
// dcache_access_stage: direct-mapped write-through data cache stage with line fill and wb register
module dcache_access_stage
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_in,
  input  logic [15:0] st_data_in,
  input  logic [1:0]  ldst_in,
  input  logic [2:0]  destReg_in,
  input  logic        we_in,
  input  logic [1:0]  bp_in,
  input  logic [2:0]  tail_rob_in,
  input  logic [15:0] pc_in,
  input  logic [1:0]  ex_vector_in,
  input  logic        ticketWE_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] wb_result,
  output logic [2:0]  wb_destReg,
  output logic        wb_we,
  output logic [1:0]  wb_bp,
  output logic [2:0]  wb_tail_rob,
  output logic [15:0] wb_pc,
  output logic [1:0]  wb_ex_vector,
  output logic        wb_ticketWE
);
  state_e state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d, off, arr_off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag, rd_tag;
  logic [DATA_W-1:0]   rd_data, arr_wdata;
  logic is_ld, is_st, hit, rd_valid, arr_we, tag_we;
  assign off   = addr_in[OFFSET_W:1];
  assign idx   = addr_in[OFFSET_W+INDEX_W:OFFSET_W+1];
  assign tag   = addr_in[ADDR_W-1 -: TAG_W];
  assign is_ld = ldst_in == LDST_LOAD && ex_vector_in == 2'b00;
  assign is_st = ldst_in == LDST_STORE && ex_vector_in == 2'b00;
  assign hit   = rd_valid && rd_tag == tag;
  dcache_array u_array (
    .clk       (clk),
    .reset     (reset),
    .idx_i     (idx),
    .rd_off_i  (off),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (arr_we),
    .wr_off_i  (arr_off),
    .wr_data_i (arr_wdata),
    .tag_we_i  (tag_we),
    .tag_i     (tag)
  );
  // state and fill word counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // next state, stall, memory request and array write controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_in;
    mem_wdata = st_data_in;
    arr_we    = 1'b0;
    arr_off   = off;
    arr_wdata = st_data_in;
    tag_we    = 1'b0;
    case (state_q)
      IDLE:
        if (is_ld && !hit) begin
          stall   = 1'b1;
          state_d = FILL;
          cnt_d   = '0;
        end else if (is_st) begin
          stall   = 1'b1;
          state_d = WRITE;
          arr_we  = hit;
        end
      FILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {addr_in[ADDR_W-1:OFFSET_W+1], cnt_q, 1'b0};
        arr_off   = cnt_q;
        arr_wdata = mem_rdata;
        arr_we    = mem_ack;
        cnt_d     = mem_ack ? cnt_q + 1'b1 : cnt_q;
        tag_we    = mem_ack && cnt_q == OFFSET_W'(LINE_WORDS - 1);
        state_d   = tag_we ? REPLAY : FILL;
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = !mem_ack;
        state_d = mem_ack ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  // writeback register: bubble while stalled, otherwise capture result and forwarded fields
  always_ff @(posedge clk or negedge reset)
    if (!reset || stall) begin
      wb_result    <= '0;
      wb_destReg   <= '0;
      wb_we        <= 1'b0;
      wb_bp        <= '0;
      wb_tail_rob  <= '0;
      wb_pc        <= '0;
      wb_ex_vector <= '0;
      wb_ticketWE  <= 1'b0;
    end else begin
      wb_result    <= is_ld ? rd_data : addr_in;
      wb_destReg   <= destReg_in;
      wb_we        <= we_in;
      wb_bp        <= bp_in;
      wb_tail_rob  <= tail_rob_in;
      wb_pc        <= pc_in;
      wb_ex_vector <= ex_vector_in;
      wb_ticketWE  <= ticketWE_in;
    end
endmodule

// File: tb/tb_dcache_access_stage.sv
// tb_dcache_access_stage: randomized self-checking bench with a memory/cache reference model
module tb_dcache_access_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] addr_in = '0, st_data_in = '0, pc_in = '0, mem_addr, mem_wdata, mem_rdata = '0, wb_result, wb_pc;
  logic [1:0] ldst_in = '0, bp_in = '0, ex_vector_in = '0, wb_bp, wb_ex_vector;
  logic [2:0] destReg_in = '0, tail_rob_in = '0, wb_destReg, wb_tail_rob;
  logic we_in = 1'b0, ticketWE_in = 1'b0, stall, mem_req, mem_we, mem_ack = 1'b0, wb_we, wb_ticketWE;
  int checks = 0, failures = 0, st;
  logic [15:0] mem [32768];
  logic mv [16];
  logic [8:0] mt [16];
  always #5 clk = ~clk;
  dcache_access_stage dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .st_data_in(st_data_in), .ldst_in(ldst_in),
    .destReg_in(destReg_in), .we_in(we_in), .bp_in(bp_in), .tail_rob_in(tail_rob_in), .pc_in(pc_in),
    .ex_vector_in(ex_vector_in), .ticketWE_in(ticketWE_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_result(wb_result), .wb_destReg(wb_destReg), .wb_we(wb_we), .wb_bp(wb_bp), .wb_tail_rob(wb_tail_rob),
    .wb_pc(wb_pc), .wb_ex_vector(wb_ex_vector), .wb_ticketWE(wb_ticketWE)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  function automatic logic [43:0] wbv();
    return {wb_result, wb_destReg, wb_we, wb_bp, wb_tail_rob, wb_pc, wb_ex_vector, wb_ticketWE};
  endfunction
  // one instruction: held until the model says it completes; every cycle checked against the model
  task automatic do_op(input logic [15:0] a, input logic [1:0] ls, input logic [15:0] d, input logic [1:0] ev,
                       input int lat, input int abort_k, output int stalls);
    logic ld, sto, hit, s, es, done;
    logic [27:0] fw;
    logic [3:0] ix;
    int ph, k, rq, cyc;
    ix = a[6:3];
    ld = ls == 2'b01 && ev == 2'b00;
    sto = ls == 2'b10 && ev == 2'b00;
    hit = mv[ix] && mt[ix] == a[15:7];
    @(negedge clk);
    addr_in = a; ldst_in = ls; st_data_in = d; ex_vector_in = ev;
    destReg_in = 3'($urandom); we_in = 1'($urandom); bp_in = 2'($urandom);
    tail_rob_in = 3'($urandom); pc_in = 16'($urandom); ticketWE_in = 1'($urandom);
    fw = {destReg_in, we_in, bp_in, tail_rob_in, pc_in, ev, ticketWE_in};
    ph = 0; k = 0; rq = 0; cyc = 0; stalls = 0; done = 1'b0;
    while (!done) begin
      mem_ack = 1'b0;
      #1;
      if (ph == 1) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, sto);
        chk("mem_addr", mem_addr, sto ? a : {a[15:3], k[1:0], 1'b0});
        if (sto) chk("mem_wdata", mem_wdata, d);
        rq++;
        if (ld && k == abort_k) begin
          reset = 1'b0;
          ldst_in = 2'b00;
          #1;
          chk("reset_mem_req", mem_req, 0);
          chk("reset_wb", wbv(), 0);
          for (int i = 0; i < 16; i++) mv[i] = 1'b0;
          @(posedge clk);
          @(negedge clk);
          reset = 1'b1;
          stalls = -1;
          return;
        end
        if (rq >= lat) begin
          mem_ack = 1'b1;
          mem_rdata = sto ? 16'($urandom) : mem[{a[15:3], k[1:0]}];
        end
      end else begin
        chk("mem_req_idle", mem_req, 0);
        mem_ack = $urandom_range(0, 3) == 0;
        mem_rdata = 16'($urandom);
      end
      #1;
      s = stall;
      es = ph == 0 ? ((ld && !hit) || sto) : ph == 1 ? (ld || !mem_ack) : 1'b0;
      chk("stall", s, es);
      if (ph == 0) begin
        if (es) ph = 1; else done = 1'b1;
      end else if (ph == 1 && mem_ack) begin
        if (sto) begin
          mem[a[15:1]] = d;
          done = 1'b1;
        end else begin
          k++; rq = 0;
          if (k == 4) begin ph = 2; mv[ix] = 1'b1; mt[ix] = a[15:7]; end
        end
      end else if (ph == 2) done = 1'b1;
      stalls += int'(s);
      @(posedge clk);
      #1;
      if (s) chk("bubble", wbv(), 0);
      else chk("wb", wbv(), {ld ? mem[a[15:1]] : a, fw});
      if (++cyc > 40) begin
        checks++; failures++;
        $display("FAIL timeout addr=%0h cycles=%0d required<=40", a, cyc);
        return;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 40503) ^ 16'h1234;
    for (int i = 0; i < 4; i++) mem[128 + i] = 16'(8'hA0 + i);
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_wb_state", wbv(), 0);
    chk("reset_mem_req_state", mem_req, 0);
    chk("reset_stall_state", stall, 0);
    reset = 1'b1;
    do_op(16'h0104, 2'b01, 16'h0, 2'b00, 1, 2, st);
    do_op(16'h0104, 2'b01, 16'h0, 2'b00, 1, -1, st);
    chk("cold_stalls", st, 5);
    chk("cold_data", wb_result, 16'h00A2);
    do_op(16'h0106, 2'b01, 16'h0, 2'b00, 1, -1, st);
    chk("hit_stalls", st, 0);
    chk("hit_data", wb_result, 16'h00A3);
    do_op(16'h0102, 2'b10, 16'h5555, 2'b00, 3, -1, st);
    chk("store_hit_stalls", st, 3);
    do_op(16'h0102, 2'b01, 16'h0, 2'b00, 1, -1, st);
    chk("store_hit_data", wb_result, 16'h5555);
    do_op(16'h0902, 2'b10, 16'h1234, 2'b00, 1, -1, st);
    chk("store_miss_stalls", st, 1);
    do_op(16'h0102, 2'b01, 16'h0, 2'b00, 1, -1, st);
    chk("after_miss_stalls", st, 0);
    chk("after_miss_data", wb_result, 16'h5555);
    do_op(16'h0902, 2'b01, 16'h0, 2'b00, 1, -1, st);
    chk("refill_stalls", st, 5);
    chk("refill_data", wb_result, 16'h1234);
    do_op(16'h0202, 2'b01, 16'h0, 2'b01, 1, -1, st);
    chk("exc_stalls", st, 0);
    chk("exc_result", wb_result, 16'h0202);
    chk("exc_vector", wb_ex_vector, 2'b01);
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = {7'($urandom_range(0, 3)), 2'b00, 4'($urandom), 2'($urandom), 1'($urandom)};
      do_op(a, 2'($urandom), 16'($urandom), $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(1, 3), -1, st);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
